// File: rtl/cia_timer.sv
// CIA 16-bit interval timer: latch, down-counter, underflow pulse
// and PB6/PB7 output, all state advanced on the phi2_dn enable.
module cia_timer #(
    parameter logic [3:0] ADDR_LO = 4'h4
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       phi2_dn,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] data,
    input  logic       ctrl_start,
    input  logic       ctrl_count,
    input  logic       ctrl_force_ld,
    input  logic [1:0] ctrl_outmode,
    output logic [7:0] rdata,
    output logic       timer_int,
    output logic       pb_out,
    output logic       pb_oe
);

    localparam logic [3:0] ADDR_HI = ADDR_LO + 4'd1;

    logic [15:0] latch_q, latch_d;
    logic [15:0] cnt_q, cnt_d;
    logic        int_q, int_d;
    logic        pb_q, pb_d;
    logic        start_prev_q, start_prev_d;

    logic wr_lo, wr_hi, underflow, load, start_rise;

    assign wr_lo      = we && (addr == ADDR_LO);
    assign wr_hi      = we && (addr == ADDR_HI);
    assign underflow  = ctrl_count && (cnt_q == 16'h0000);
    assign load       = ctrl_force_ld || underflow || (wr_hi && !ctrl_start);
    assign start_rise = ctrl_start && !start_prev_q;

    always_comb begin
        latch_d      = latch_q;
        cnt_d        = cnt_q;
        int_d        = int_q;
        pb_d         = pb_q;
        start_prev_d = start_prev_q;
        if (phi2_dn) begin
            if (wr_lo) latch_d[7:0]  = data;
            if (wr_hi) latch_d[15:8] = data;
            if (load)
                cnt_d = latch_d;
            else if (ctrl_count)
                cnt_d = cnt_q - 16'd1;
            int_d = underflow;
            // start edge forces the toggle output high, even over an underflow
            if (start_rise)
                pb_d = 1'b1;
            else if (underflow)
                pb_d = !pb_q;
            start_prev_d = ctrl_start;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            latch_q      <= 16'hFFFF;
            cnt_q        <= 16'hFFFF;
            int_q        <= 1'b0;
            pb_q         <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            latch_q      <= latch_d;
            cnt_q        <= cnt_d;
            int_q        <= int_d;
            pb_q         <= pb_d;
            start_prev_q <= start_prev_d;
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (addr == ADDR_LO)
            rdata = cnt_q[7:0];
        else if (addr == ADDR_HI)
            rdata = cnt_q[15:8];
    end

    assign timer_int = int_q;
    assign pb_out    = ctrl_outmode[1] ? pb_q : int_q;
    assign pb_oe     = ctrl_outmode[0];

endmodule

// File: tb/tb_cia_timer.sv
// Bench for cia_timer: vector table with scoreboard queue plus
// hand sequences for reset behaviour.
module tb_cia_timer;

    localparam logic [3:0] A_LO = 4'h4;
    localparam logic [3:0] A_HI = 4'h5;

    logic       clk = 1'b0;
    logic       res_n;
    logic       phi2_dn;
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic       ctrl_start;
    logic       ctrl_count;
    logic       ctrl_force_ld;
    logic [1:0] ctrl_outmode;
    logic [7:0] rdata;
    logic       timer_int;
    logic       pb_out;
    logic       pb_oe;

    int checks = 0;
    int failures = 0;

    cia_timer #(.ADDR_LO(A_LO)) dut (
        .clk(clk), .res_n(res_n), .phi2_dn(phi2_dn), .we(we),
        .addr(addr), .data(data), .ctrl_start(ctrl_start),
        .ctrl_count(ctrl_count), .ctrl_force_ld(ctrl_force_ld),
        .ctrl_outmode(ctrl_outmode), .rdata(rdata),
        .timer_int(timer_int), .pb_out(pb_out), .pb_oe(pb_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [7:0]  data;
        logic        st;
        logic        cn;
        logic        fld;
        logic [1:0]  om;
        logic [15:0] ecnt;
        logic        eint;
        logic        epb;
    } vec_t;

    typedef struct {
        logic [15:0] c;
        logic        i;
        logic        p;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];

    function automatic vec_t mk(logic w, logic [3:0] a, logic [7:0] d,
                                logic s, logic c, logic f, logic [1:0] o,
                                logic [15:0] ec, logic ei, logic ep);
        vec_t v;
        v.we = w; v.addr = a; v.data = d; v.st = s; v.cn = c;
        v.fld = f; v.om = o; v.ecnt = ec; v.eint = ei; v.epb = ep;
        return v;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic read_cnt(output logic [15:0] v);
        addr = A_LO;
        #1 v[7:0] = rdata;
        addr = A_HI;
        #1 v[15:8] = rdata;
    endtask

    task automatic apply(vec_t v, int idx);
        exp_t e;
        exp_t got;
        logic [15:0] c;
        we = v.we; addr = v.addr; data = v.data;
        ctrl_start = v.st; ctrl_count = v.cn;
        ctrl_force_ld = v.fld; ctrl_outmode = v.om;
        e.c = v.ecnt; e.i = v.eint; e.p = v.epb;
        sb.push_back(e);
        phi2_dn = 1'b1;
        @(posedge clk);
        #1 phi2_dn = 1'b0;
        // second edge without strobe: state must hold
        @(posedge clk);
        #1;
        we = 1'b0;
        read_cnt(c);
        got = sb.pop_front();
        chk($sformatf("v%0d_cnt", idx), c, got.c);
        chk($sformatf("v%0d_int", idx), {15'd0, timer_int}, {15'd0, got.i});
        chk($sformatf("v%0d_pb", idx), {15'd0, pb_out}, {15'd0, got.p});
    endtask

    initial begin
        logic [15:0] c;
        res_n = 1'b0; phi2_dn = 1'b0; we = 1'b0; addr = 4'h0;
        data = 8'h00; ctrl_start = 1'b0; ctrl_count = 1'b0;
        ctrl_force_ld = 1'b0; ctrl_outmode = 2'b00;

        //        we   addr  data   st cn fl om     cnt      int  pb
        tv.push_back(mk(1, A_LO, 8'h03, 0, 0, 0, 2'b00, 16'hFFFF, 0, 0));
        tv.push_back(mk(1, A_HI, 8'h00, 0, 0, 0, 2'b00, 16'h0003, 0, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 0, 1, 0, 2'b00, 16'h0002, 0, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 0, 1, 0, 2'b00, 16'h0001, 0, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 0, 1, 0, 2'b00, 16'h0000, 0, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 0, 1, 0, 2'b00, 16'h0003, 1, 1));
        tv.push_back(mk(0, A_LO, 8'h00, 0, 0, 0, 2'b00, 16'h0003, 0, 0));
        tv.push_back(mk(1, A_LO, 8'h10, 0, 0, 0, 2'b00, 16'h0003, 0, 0));
        tv.push_back(mk(1, A_HI, 8'h00, 0, 0, 0, 2'b00, 16'h0010, 0, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 0, 2'b00, 16'h000F, 0, 0));
        tv.push_back(mk(1, A_LO, 8'h20, 1, 1, 0, 2'b00, 16'h000E, 0, 0));
        tv.push_back(mk(1, A_HI, 8'h00, 1, 1, 0, 2'b00, 16'h000D, 0, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 1, 2'b00, 16'h0020, 0, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 0, 2'b00, 16'h001F, 0, 0));
        tv.push_back(mk(1, A_LO, 8'h01, 0, 0, 0, 2'b10, 16'h001F, 0, 1));
        tv.push_back(mk(1, A_HI, 8'h00, 0, 0, 0, 2'b10, 16'h0001, 0, 1));
        tv.push_back(mk(0, A_LO, 8'h00, 0, 1, 0, 2'b10, 16'h0000, 0, 1));
        tv.push_back(mk(0, A_LO, 8'h00, 0, 1, 0, 2'b10, 16'h0001, 1, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 0, 2'b10, 16'h0000, 0, 1));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 0, 2'b10, 16'h0001, 1, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 0, 2'b10, 16'h0000, 0, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 0, 2'b10, 16'h0001, 1, 1));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 0, 2'b10, 16'h0000, 0, 1));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 0, 2'b10, 16'h0001, 1, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 0, 2'b00, 16'h0000, 0, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 0, 2'b00, 16'h0001, 1, 1));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 0, 2'b00, 16'h0000, 0, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 0, 1, 0, 2'b10, 16'h0001, 1, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 0, 0, 2'b10, 16'h0001, 0, 1));
        tv.push_back(mk(0, A_LO, 8'h00, 0, 1, 0, 2'b10, 16'h0000, 0, 1));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 0, 2'b10, 16'h0001, 1, 1));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 0, 2'b00, 16'h0000, 0, 0));
        tv.push_back(mk(1, A_LO, 8'h05, 1, 0, 0, 2'b00, 16'h0000, 0, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 1, 1, 2'b00, 16'h0005, 1, 1));
        tv.push_back(mk(0, A_LO, 8'h00, 1, 0, 0, 2'b00, 16'h0005, 0, 0));
        tv.push_back(mk(1, A_LO, 8'h00, 0, 0, 0, 2'b00, 16'h0005, 0, 0));
        tv.push_back(mk(1, A_HI, 8'h00, 0, 0, 0, 2'b00, 16'h0000, 0, 0));
        tv.push_back(mk(0, A_LO, 8'h00, 0, 1, 0, 2'b00, 16'h0000, 1, 1));
        tv.push_back(mk(0, A_LO, 8'h00, 0, 1, 0, 2'b00, 16'h0000, 1, 1));

        repeat (2) @(posedge clk);
        #1;
        read_cnt(c);
        chk("rst_cnt", c, 16'hFFFF);
        chk("rst_int", {15'd0, timer_int}, 16'd0);
        chk("rst_pb", {15'd0, pb_out}, 16'd0);
        addr = 4'h0;
        #1 chk("rdata_other0", {8'd0, rdata}, 16'h0000);
        addr = 4'h6;
        #1 chk("rdata_other6", {8'd0, rdata}, 16'h0000);
        res_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tv.size(); i++)
            apply(tv[i], i);

        // async reset between strobes while counting with timer_int high
        ctrl_count = 1'b1;
        @(negedge clk);
        res_n = 1'b0;
        #1;
        chk("arst_int", {15'd0, timer_int}, 16'd0);
        chk("arst_pb", {15'd0, pb_out}, 16'd0);
        read_cnt(c);
        chk("arst_cnt", c, 16'hFFFF);
        @(posedge clk);
        #1 res_n = 1'b1;
        @(posedge clk);
        #1;
        apply(mk(0, A_LO, 8'h00, 0, 1, 0, 2'b00, 16'hFFFE, 0, 0), 100);
        apply(mk(0, A_LO, 8'h00, 0, 0, 1, 2'b00, 16'hFFFF, 0, 0), 101);

        ctrl_outmode = 2'b01;
        #1 chk("pb_oe_on", {15'd0, pb_oe}, 16'd1);
        ctrl_outmode = 2'b10;
        #1 chk("pb_oe_off", {15'd0, pb_oe}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
